// File: rtl/conv_mac.sv
// conv_mac: N x N window multiply-accumulate with programmable signed
// coefficients, 4-stage pipeline (products, row sums, total, round/shift/clamp).
// Coefficients are loaded through a shadow bank and committed atomically.
// Optional macro CONV_MAC_SAT_CNT_EN enables the clipped-output counter on
// sat_cnt_o; without it sat_cnt_o is tied to 0.

package conv_pkg;
  localparam int unsigned KERNEL_DIAMETER_N = 5;
  localparam int unsigned PIXEL_W           = 8;
  localparam int unsigned KERNEL_POS_W      = 16;

  typedef logic [KERNEL_DIAMETER_N-1:0][KERNEL_DIAMETER_N-1:0][PIXEL_W-1:0] kernel_t;
  typedef logic [KERNEL_POS_W-1:0] kernel_pos_t;
endpackage

module conv_mac #(
  parameter int unsigned KERNEL_DIAMETER_N = conv_pkg::KERNEL_DIAMETER_N,
  parameter int unsigned PIXEL_W           = conv_pkg::PIXEL_W,
  parameter int unsigned COEFF_W           = 8,
  parameter int unsigned SHIFT_W           = 4
) (
  input  logic                                                          clk,
  input  logic                                                          arst_n,
  input  logic                                                          kernel_vld_i,
  input  logic [KERNEL_DIAMETER_N-1:0][KERNEL_DIAMETER_N-1:0][PIXEL_W-1:0] kernel_dat_i,
  input  conv_pkg::kernel_pos_t                                         kernel_pos_i,
  input  logic                                                          coeff_start_i,
  input  logic                                                          coeff_wr_i,
  input  logic [COEFF_W-1:0]                                            coeff_dat_i,
  input  logic [SHIFT_W-1:0]                                            cfg_shift_i,
  output logic                                                          coeff_busy_o,
  output logic                                                          coeff_err_o,
  output logic                                                          out_vld_o,
  output logic [PIXEL_W-1:0]                                            out_dat_o,
  output conv_pkg::kernel_pos_t                                         out_pos_o,
  output logic [15:0]                                                   sat_cnt_o
);

  localparam int unsigned N      = KERNEL_DIAMETER_N;
  localparam int unsigned NN     = N * N;
  localparam int unsigned IDX_W  = (NN > 1) ? $clog2(NN) : 1;
  localparam int unsigned PROD_W = PIXEL_W + COEFF_W + 1;
  localparam int unsigned ACC_W  = PIXEL_W + COEFF_W + 6;
  localparam int unsigned CENTRE = (N / 2) * N + (N / 2);
  localparam int          PIX_MAX = (1 << PIXEL_W) - 1;

  typedef enum logic {ST_IDLE, ST_LOAD} state_t;

  state_t                     r_state, w_state_nxt;
  logic [IDX_W-1:0]           r_idx, w_idx_nxt, w_widx;
  logic                       w_wr_en, w_commit, w_err;
  logic                       r_err;
  logic signed [COEFF_W-1:0]  r_shadow [NN];
  logic signed [COEFF_W-1:0]  r_coeff  [NN];
  logic [SHIFT_W-1:0]         r_shift;

  // Load sequencer: start resets the index first, so a coincident write lands at 0
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_widx      = r_idx;
    w_wr_en     = 1'b0;
    w_commit    = 1'b0;
    w_err       = 1'b0;
    if (coeff_start_i) begin
      w_state_nxt = ST_LOAD;
      w_idx_nxt   = '0;
      w_widx      = '0;
    end
    if (coeff_wr_i) begin
      if (coeff_start_i || (r_state == ST_LOAD)) begin
        w_wr_en = 1'b1;
        if (w_widx == IDX_W'(NN - 1)) begin
          w_commit    = 1'b1;
          w_state_nxt = ST_IDLE;
          w_idx_nxt   = '0;
        end else begin
          w_idx_nxt = w_widx + IDX_W'(1);
        end
      end else begin
        w_err = 1'b1;
      end
    end
  end

  // Sequencer state, index and error pulse
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_err   <= w_err;
    end
  end

  // Shadow bank; the final write bypasses into the active bank on commit
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int unsigned i = 0; i < NN; i++) begin
        r_shadow[i] <= '0;
        r_coeff[i]  <= (i == CENTRE) ? COEFF_W'(1) : '0;
      end
      r_shift <= '0;
    end else begin
      for (int unsigned i = 0; i < NN; i++) begin
        if (w_wr_en && (w_widx == IDX_W'(i)))
          r_shadow[i] <= coeff_dat_i;
        if (w_commit)
          r_coeff[i] <= (i == NN - 1) ? coeff_dat_i : r_shadow[i];
      end
      if (w_commit)
        r_shift <= cfg_shift_i;
    end
  end

  assign coeff_busy_o = (r_state == ST_LOAD);
  assign coeff_err_o  = r_err;

  // ---------------- datapath ----------------
  logic signed [PROD_W-1:0]   w_prod [NN];
  logic signed [PROD_W-1:0]   r_prod [NN];
  logic signed [ACC_W-1:0]    w_row  [N];
  logic signed [ACC_W-1:0]    r_row  [N];
  logic signed [ACC_W-1:0]    w_sum, r_sum;
  logic signed [ACC_W-1:0]    w_bias, w_rnd, w_shf;
  logic [PIXEL_W-1:0]         w_pix;
  logic [SHIFT_W-1:0]         r_sh1, r_sh2, r_sh3;
  logic                       r_vld1, r_vld2, r_vld3;
  conv_pkg::kernel_pos_t      r_pos1, r_pos2, r_pos3;
  logic                       r_out_vld;
  logic [PIXEL_W-1:0]         r_out_dat;
  conv_pkg::kernel_pos_t      r_out_pos;

  // Stage 1 operands: pixel zero-extended, coefficient sign-extended
  always_comb begin
    for (int unsigned i = 0; i < NN; i++) begin
      w_prod[i] = $signed({{(COEFF_W + 1){1'b0}}, kernel_dat_i[i / N][i % N]})
                * $signed({{(PIXEL_W + 1){r_coeff[i][COEFF_W-1]}}, r_coeff[i]});
    end
  end

  // Stage 2 operands: per-row sums
  always_comb begin
    for (int unsigned r = 0; r < N; r++) begin
      w_row[r] = '0;
      for (int unsigned c = 0; c < N; c++)
        w_row[r] = w_row[r] + ACC_W'(r_prod[r * N + c]);
    end
  end

  // Stage 3 operand: total of row sums
  always_comb begin
    w_sum = '0;
    for (int unsigned r = 0; r < N; r++)
      w_sum = w_sum + r_row[r];
  end

  // Stage 4 operand: round half-up, arithmetic shift, clamp to pixel range
  always_comb begin
    w_bias = '0;
    if (r_sh3 != '0)
      w_bias[r_sh3 - SHIFT_W'(1)] = 1'b1;
    w_rnd = r_sum + w_bias;
    w_shf = w_rnd >>> r_sh3;
    if (w_shf < 0)
      w_pix = '0;
    else if (w_shf > $signed(ACC_W'(PIX_MAX)))
      w_pix = '1;
    else
      w_pix = w_shf[PIXEL_W-1:0];
  end

  // Pipeline registers; shift travels with the window so a commit never splits a result
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int unsigned i = 0; i < NN; i++) r_prod[i] <= '0;
      for (int unsigned r = 0; r < N; r++)  r_row[r]  <= '0;
      r_sum  <= '0;
      r_sh1  <= '0;
      r_sh2  <= '0;
      r_sh3  <= '0;
      r_vld1 <= 1'b0;
      r_vld2 <= 1'b0;
      r_vld3 <= 1'b0;
      r_pos1 <= '0;
      r_pos2 <= '0;
      r_pos3 <= '0;
    end else begin
      for (int unsigned i = 0; i < NN; i++) r_prod[i] <= w_prod[i];
      for (int unsigned r = 0; r < N; r++)  r_row[r]  <= w_row[r];
      r_sum  <= w_sum;
      r_sh1  <= r_shift;
      r_sh2  <= r_sh1;
      r_sh3  <= r_sh2;
      r_vld1 <= kernel_vld_i;
      r_vld2 <= r_vld1;
      r_vld3 <= r_vld2;
      r_pos1 <= kernel_pos_i;
      r_pos2 <= r_pos1;
      r_pos3 <= r_pos2;
    end
  end

  // Output registers hold their last result while no result is valid
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_out_vld <= 1'b0;
      r_out_dat <= '0;
      r_out_pos <= '0;
    end else begin
      r_out_vld <= r_vld3;
      if (r_vld3) begin
        r_out_dat <= w_pix;
        r_out_pos <= r_pos3;
      end
    end
  end

  assign out_vld_o = r_out_vld;
  assign out_dat_o = r_out_dat;
  assign out_pos_o = r_out_pos;

`ifdef CONV_MAC_SAT_CNT_EN
  logic        w_clamp;
  logic [15:0] r_sat_cnt;

  assign w_clamp = (w_shf < 0) || (w_shf > $signed(ACC_W'(PIX_MAX)));

  // Clipped-result counter; a load start clears it and takes priority
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n)
      r_sat_cnt <= '0;
    else if (coeff_start_i)
      r_sat_cnt <= '0;
    else if (r_vld3 && w_clamp && (r_sat_cnt != '1))
      r_sat_cnt <= r_sat_cnt + 16'd1;
  end

  assign sat_cnt_o = r_sat_cnt;
`else
  assign sat_cnt_o = '0;
`endif

endmodule

// File: tb/tb_conv_mac.sv
// tb_conv_mac: randomized self-checking bench for conv_mac with an
// arithmetic reference model of the convolution and the coefficient loader.
module tb_conv_mac;
  localparam int N  = 5;
  localparam int NN = N * N;

  logic                        clk = 1'b0;
  logic                        arst_n;
  logic                        vld;
  logic [N-1:0][N-1:0][7:0]    win;
  logic [15:0]                 pos;
  logic                        start, wr;
  logic [7:0]                  cdat;
  logic [3:0]                  cfg_sh;
  logic                        busy, err, out_vld;
  logic [7:0]                  out_dat;
  logic [15:0]                 out_pos;
  logic [15:0]                 sat_cnt;

  always #5 clk = ~clk;

  conv_mac dut (
    .clk           (clk),
    .arst_n        (arst_n),
    .kernel_vld_i  (vld),
    .kernel_dat_i  (win),
    .kernel_pos_i  (pos),
    .coeff_start_i (start),
    .coeff_wr_i    (wr),
    .coeff_dat_i   (cdat),
    .cfg_shift_i   (cfg_sh),
    .coeff_busy_o  (busy),
    .coeff_err_o   (err),
    .out_vld_o     (out_vld),
    .out_dat_o     (out_dat),
    .out_pos_o     (out_pos),
    .sat_cnt_o     (sat_cnt)
  );

  typedef struct {
    int          due;
    int          dat;
    logic [15:0] pos;
    bit          clamp;
  } exp_t;

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   mcoeff  [NN];
  int   mshadow [NN];
  int   mshift;
  bit   mload;
  int   midx;
  int   msat;
  int   last_dat, last_pos;
  int   ld_c [NN];
  exp_t q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
    end
  endtask

  function automatic int ref_pix(input logic [N-1:0][N-1:0][7:0] w, output bit clamp);
    int s = 0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        s += int'(w[r][c]) * mcoeff[r * N + c];
    if (mshift > 0) s = (s + (1 << (mshift - 1))) >>> mshift;
    clamp = (s < 0) || (s > 255);
    if (s < 0)   return 0;
    if (s > 255) return 255;
    return s;
  endfunction

  task automatic model_reset();
    q.delete();
    for (int i = 0; i < NN; i++) begin
      mcoeff[i]  = (i == (N / 2) * N + N / 2) ? 1 : 0;
      mshadow[i] = 0;
    end
    mshift = 0; mload = 0; midx = 0; msat = 0;
    last_dat = 0; last_pos = 0;
  endtask

  task automatic set_idle();
    vld = 0; start = 0; wr = 0;
  endtask

  // One clock: update the model from current inputs, advance, compare outputs
  task automatic step();
    bit   e_err = 0;
    bit   clr   = 0;
    bit   ev;
    exp_t e;
    if (arst_n) begin
      if (vld) begin
        e.due = cyc + 4;
        e.dat = ref_pix(win, e.clamp);
        e.pos = pos;
        q.push_back(e);
      end
      e_err = wr && !start && !mload;
      clr   = start;
      if (start) begin mload = 1; midx = 0; end
      if (wr && mload) begin
        mshadow[midx] = int'($signed(cdat));
        if (midx == NN - 1) begin
          mcoeff = mshadow;
          mshift = int'(cfg_sh);
          mload  = 0;
          midx   = 0;
        end else begin
          midx++;
        end
      end
    end
    @(posedge clk); #1;
    cyc++;
    ev = (q.size() > 0) && (q[0].due == cyc);
    check("out_vld", out_vld, ev);
    if (ev) begin
      e = q.pop_front();
      last_dat = e.dat;
      last_pos = int'(e.pos);
      if (clr) msat = 0;
      else if (e.clamp && msat < 65535) msat++;
    end else if (clr) begin
      msat = 0;
    end
    check("out_dat", out_dat, last_dat);
    check("out_pos", out_pos, last_pos);
    check("coeff_err", err, e_err);
    check("coeff_busy", busy, mload);
`ifdef CONV_MAC_SAT_CNT_EN
    check("sat_cnt", sat_cnt, msat);
`else
    check("sat_cnt", sat_cnt, 0);
`endif
  endtask

  task automatic idle(input int n);
    set_idle();
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic fill(input int v);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        win[r][c] = 8'(v);
  endtask

  task automatic rand_win();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        win[r][c] = 8'($urandom);
    pos = 16'($urandom);
  endtask

  task automatic load(input int sh);
    cfg_sh = 4'(sh);
    for (int i = 0; i < NN; i++) begin
      start = (i == 0); wr = 1; cdat = 8'(ld_c[i]);
      step();
    end
    set_idle();
  endtask

  task automatic one_window(input int v);
    fill(v); pos = 16'($urandom); vld = 1;
    step();
    idle(5);
  endtask

  task automatic do_reset();
    arst_n = 0;
    model_reset();
    #2;
    check("rst_vld", out_vld, 0);
    check("rst_busy", busy, 0);
    check("rst_dat", out_dat, 0);
    set_idle();
    step();
    step();
    arst_n = 1;
  endtask

  initial begin
    logic [15:0] p0;
    logic [7:0]  ctr;
    int          sat_exp;
    arst_n = 0; set_idle(); win = '0; pos = '0; cdat = '0; cfg_sh = '0;
    model_reset();
    #12;
    check("reset_vld", out_vld, 0);
    check("reset_dat", out_dat, 0);
    check("reset_pos", out_pos, 0);
    check("reset_busy", busy, 0);
    check("reset_err", err, 0);
    check("reset_sat", sat_cnt, 0);
    @(posedge clk); #1;
    arst_n = 1;

    // Identity passthrough
    fill(7); win[2][2] = 8'd200; pos = 16'h1234; p0 = pos; vld = 1;
    step();
    idle(5);
    check("pass200", out_dat, 200);
    check("pass_pos", out_pos, p0);

    // All ones, shift 0: sum and high clamp
    for (int i = 0; i < NN; i++) ld_c[i] = 1;
    load(0);
    one_window(10);
    check("sum250", out_dat, 250);
    one_window(11);
    check("sat255", out_dat, 255);
`ifdef CONV_MAC_SAT_CNT_EN
    sat_exp = 1;
`else
    sat_exp = 0;
`endif
    check("satcnt1", sat_cnt, sat_exp);

    // Rounding with shift 3, then low clamp
    load(3);
    one_window(1);
    check("round3", out_dat, 3);
    for (int i = 0; i < NN; i++) ld_c[i] = 0;
    ld_c[(N / 2) * N + N / 2] = -1;
    load(0);
    one_window(50);
    check("clamp_lo", out_dat, 0);

    // Commit lands on B's entry cycle: A and B old set, C new set
    for (int i = 0; i < NN; i++) ld_c[i] = $urandom_range(0, 6) - 3;
    cfg_sh = 4'd2;
    for (int i = 0; i < NN; i++) begin
      start = (i == 0); wr = 1; cdat = 8'(ld_c[i]);
      vld = (i >= NN - 2);
      if (vld) rand_win();
      step();
    end
    set_idle(); vld = 1; rand_win();
    step();
    idle(5);

    // Write outside a sequence: error pulse, coefficients untouched
    wr = 1; cdat = 8'h55;
    step();
    idle(1);
    vld = 1; rand_win();
    step();
    idle(5);

    // Restart at write 10: index resets, commit only after 25 more writes
    for (int i = 0; i < NN; i++) ld_c[i] = $urandom_range(0, 4) - 2;
    cfg_sh = 4'd1;
    for (int i = 0; i < 10; i++) begin
      start = (i == 0); wr = 1; cdat = 8'($urandom_range(0, 255));
      step();
    end
    for (int i = 0; i < NN; i++) begin
      start = (i == 0); wr = 1; cdat = 8'(ld_c[i]);
      step();
      if (i == NN - 2) check("busy_before_commit", busy, 1);
    end
    check("idle_after_commit", busy, 0);
    set_idle(); vld = 1; rand_win();
    step();
    idle(5);

    // Randomized traffic with interleaved loads and restarts
    for (int n = 0; n < 400; n++) begin
      vld = ($urandom_range(0, 3) != 0);
      rand_win();
      start = 0; wr = 0;
      if (!mload) begin
        start = ($urandom_range(0, 19) == 0);
        wr = start ? 1'b1 : ($urandom_range(0, 49) == 0);
      end else begin
        start = ($urandom_range(0, 39) == 0);
        wr = ($urandom_range(0, 9) < 7);
      end
      cdat   = 8'($urandom_range(0, 6) - 3);
      if ($urandom_range(0, 7) == 0) cdat = 8'($urandom);
      cfg_sh = 4'($urandom_range(0, 15));
      step();
    end
    idle(5);

    // Reset mid-load with windows in flight
    for (int i = 0; i < 6; i++) begin
      start = (i == 0); wr = 1; cdat = 8'($urandom);
      vld = (i >= 3);
      if (vld) rand_win();
      step();
    end
    do_reset();
    idle(6);
    check("busy_after_rst", busy, 0);
    rand_win(); vld = 1; ctr = win[2][2];
    step();
    idle(5);
    check("ident_after_rst", out_dat, ctr);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/conv_mac.md
Name: conv_mac

Overview:
- Downstream consumer of the kernel window stage.
- Takes one fully assembled KERNEL_DIAMETER_N x KERNEL_DIAMETER_N pixel window per valid cycle and multiplies each pixel by a programmable signed coefficient.
- Reduces the products through a pipelined adder tree, then rounds, shifts and clamps the result to one output pixel.
- Carries kernel position alongside; no backpressure, with a fixed latency matching the upstream stream.

Parameters:
- KERNEL_DIAMETER_N, 5, window edge length (N); N*N coefficients.
- PIXEL_W, 8, unsigned pixel width in and out.
- COEFF_W, 8, signed two's-complement coefficient width.
- SHIFT_W, 4, width of the post-sum right-shift amount.

Ports:
- clk  in  1  clock.
- arst_n  in  1  reset, asynchronous, active-low.
- kernel_vld_i  in  1  window valid.
- kernel_dat_i  in  N*N*PIXEL_W  conv_pkg::kernel_t window; element [r][c] = row r (lane), column c (oldest column = lowest c).
- kernel_pos_i  in  conv_pkg::KERNEL_POS_W  conv_pkg::kernel_pos_t position tag.
- coeff_start_i  in  1  begin coefficient load sequence.
- coeff_wr_i  in  1  coefficient write strobe.
- coeff_dat_i  in  COEFF_W  coefficient value.
- cfg_shift_i  in  SHIFT_W  shift amount, captured at commit.
- coeff_busy_o  out  1  load sequence in progress.
- coeff_err_o  out  1  one-cycle pulse on write outside a sequence.
- out_vld_o  out  1  result valid.
- out_dat_o  out  PIXEL_W  result pixel.
- out_pos_o  out  conv_pkg::KERNEL_POS_W  position tag of the result.
- sat_cnt_o  out  16  clipped-output count (see Optional Feature).

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low (arst_n).
- Reset values:
  - All outputs 0; pipeline valids 0.
  - Load FSM in IDLE; write index 0; active shift 0.
  - Active coefficients = identity: centre [N/2][N/2] = 1, all others 0. Unconfigured behaviour is therefore passthrough.
- Coefficient FSM, states IDLE and LOAD:
  - coeff_start_i in either state: state becomes LOAD, index becomes 0, partial shadow discarded.
  - If coeff_wr_i is asserted in the same cycle as coeff_start_i, the start takes effect first. That write lands at index 0 and the index advances to 1.
  - In LOAD, each coeff_wr_i writes shadow[index] and increments index. Index i maps to [i/N][i%N].
  - Commit: the write at index N*N-1 copies shadow to active and captures cfg_shift_i into active shift, then returns to IDLE. The new values apply to windows entering stage 1 on the following cycle. A window entering on the commit cycle uses the old set.
  - coeff_wr_i in IDLE without coeff_start_i is ignored and pulses coeff_err_o for one cycle.
  - coeff_busy_o = (state == LOAD).
- Datapath (no stall; a new window may arrive every cycle):
  - Stage 1: N*N products, unsigned pixel x signed coeff, each signed PIXEL_W+COEFF_W+1 bits.
  - Stage 2: N row sums.
  - Stage 3: total sum, ACC_W = PIXEL_W+COEFF_W+6 bits signed. No overflow is possible for N <= 5.
  - Stage 4, rounding: if shift > 0, add 1<<(shift-1), then arithmetic right shift by shift.
  - Stage 4, clamping: result < 0 becomes 0; result > 2^PIXEL_W-1 becomes 2^PIXEL_W-1 (saturation).
  - Latency is exactly 4 cycles from kernel_vld_i to out_vld_o. Position and valid travel the same 4-deep pipeline.
  - Output registers hold their last value when out_vld_o = 0.
  - Active shift is sampled in stage 1 and carried with the window, so a mid-pipe commit never mixes coefficient sets within one result.
- Reset mid-operation: pipeline is flushed (no out_vld_o after release until new input arrives); coefficients return to identity; any load in progress is abandoned.

Optional Feature:
- Macro: CONV_MAC_SAT_CNT_EN.
- Defined:
  - 16-bit counter increments on every out_vld_o result that was clamped (low or high).
  - Counter saturates at 0xFFFF and is cleared by reset and by coeff_start_i. A start that coincides with a clamped result clears the counter; clear wins.
  - sat_cnt_o shows the counter value.
- Undefined: no counter logic; sat_cnt_o tied to 0.

Test Plan:
- Reset then single window, all pixels 7 except centre 200 -> 4 cycles later out_vld_o=1, out_dat_o=200, out_pos_o = input pos.
- Load all coeff=1, shift=0; window of all 10 -> 250. Window of all 11 -> 255 (saturated), sat_cnt_o=1 with macro defined, 0 without.
- Load all coeff=1, shift=3; window all 1 -> (25+4)>>3 = 3. Centre coeff = -1, others 0; pixel 50 -> 0 (clamped low).
- Back-to-back windows A,B,C on consecutive cycles, commit write lands on B's entry cycle -> A and B computed with old set, C with new; no valid gaps.
- Protocol: coeff_wr_i in IDLE -> coeff_err_o single pulse, active unchanged. coeff_start_i with coeff_wr_i, then 24 writes -> commit. Restart at write 10 -> index resets, no commit until 25 further writes.
- arst_n asserted mid-LOAD with 3 windows in flight -> no out_vld_o after release, coeff_busy_o=0, identity passthrough restored.
